// File: rtl/mmu_bat_lookup.sv
// Multi-entry BAT translation unit: SPR-programmed BAT pairs, one EA lookup per cycle.
// Optional MMU_BAT_MULTIHIT_EN adds resp_multihit (more than one BAT matched).

module mmu_bat_entry (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic        wr_upper,
    input  logic [31:0] wr_data,
    input  logic        inv_all,
    input  logic [31:0] ea,
    input  logic        priv,
    output logic        match,
    output logic [31:0] pa,
    output logic [3:0]  wimg,
    output logic [1:0]  pp
);
    logic [14:0] bepi;
    logic [14:0] brpn;
    logic [10:0] bl;
    logic        vs;
    logic        vp;
    logic [10:0] blk;
    logic        unused_wr;

    // inv_all precedes the write: a BATU write in the same cycle re-arms its own V bits
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bepi <= '0;
            bl   <= '0;
            vs   <= 1'b0;
            vp   <= 1'b0;
            brpn <= '0;
            wimg <= '0;
            pp   <= '0;
        end else begin
            if (inv_all) begin
                vs <= 1'b0;
                vp <= 1'b0;
            end
            if (wr_en) begin
                if (wr_upper) begin
                    bepi <= wr_data[31:17];
                    bl   <= wr_data[12:2];
                    vs   <= wr_data[1];
                    vp   <= wr_data[0];
                end else begin
                    brpn <= wr_data[31:17];
                    wimg <= wr_data[6:3];
                    pp   <= wr_data[1:0];
                end
            end
        end
    end

    assign blk       = ea[27:17];
    assign match     = (ea[31:28] == bepi[14:11]) && ((blk & ~bl) == bepi[10:0]) &&
                       ((vs && priv) || (vp && !priv));
    assign pa        = {brpn[14:11], brpn[10:0] | (blk & bl), ea[16:0]};
    assign unused_wr = ^wr_data[16:13];
endmodule

module mmu_bat_lookup #(
    parameter int NUM_BATS    = 4,
    parameter int IDX_W       = 2,
    parameter int INSTRUCTION = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             spr_wr_en,
    input  logic [IDX_W-1:0] spr_wr_idx,
    input  logic             spr_wr_upper,
    input  logic [31:0]      spr_wr_data,
    input  logic             inv_all,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_ea,
    input  logic             req_priv,
    input  logic             req_write,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_hit,
    output logic [31:0]      resp_pa,
    output logic [3:0]       resp_wimg,
    output logic [1:0]       resp_pp,
    output logic             resp_fault,
`ifdef MMU_BAT_MULTIHIT_EN
    output logic             resp_multihit,
`endif
    output logic [IDX_W-1:0] resp_idx
);
    typedef struct packed {
        logic             hit;
        logic [31:0]      pa;
        logic [3:0]       wimg;
        logic [1:0]       pp;
        logic             fault;
        logic [IDX_W-1:0] idx;
`ifdef MMU_BAT_MULTIHIT_EN
        logic             multihit;
`endif
    } resp_t;

    logic [NUM_BATS-1:0]       match;
    logic [NUM_BATS-1:0][31:0] bat_pa;
    logic [NUM_BATS-1:0][3:0]  bat_wimg;
    logic [NUM_BATS-1:0][1:0]  bat_pp;
    resp_t                     nxt;
    resp_t                     resp_q;
    logic                      accept;

    // Out-of-range indices never decode, so those writes are dropped
    for (genvar i = 0; i < NUM_BATS; i++) begin : g_bat
        mmu_bat_entry u_entry (
            .clk      (clk),
            .reset_n  (reset_n),
            .wr_en    (spr_wr_en && (spr_wr_idx == IDX_W'(i))),
            .wr_upper (spr_wr_upper),
            .wr_data  (spr_wr_data),
            .inv_all  (inv_all),
            .ea       (req_ea),
            .priv     (req_priv),
            .match    (match[i]),
            .pa       (bat_pa[i]),
            .wimg     (bat_wimg[i]),
            .pp       (bat_pp[i])
        );
    end

    // Scan high to low so the lowest matching index is the last one written
    always_comb begin
        nxt = '0;
        for (int i = NUM_BATS - 1; i >= 0; i--) begin
            if (match[i]) begin
                nxt.hit  = 1'b1;
                nxt.pa   = bat_pa[i];
                nxt.wimg = (INSTRUCTION != 0) ? 4'b0000 : bat_wimg[i];
                nxt.pp   = bat_pp[i];
                nxt.idx  = IDX_W'(i);
            end
        end
        nxt.fault = nxt.hit && ((nxt.pp == 2'b00) ||
                                (nxt.pp[0] && req_write && (INSTRUCTION == 0)));
`ifdef MMU_BAT_MULTIHIT_EN
        nxt.multihit = |(match & (match - NUM_BATS'(1)));
`endif
    end

    assign req_ready = !resp_valid || resp_ready;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            resp_valid <= 1'b0;
            resp_q     <= '0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_q     <= nxt;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    assign resp_hit   = resp_q.hit;
    assign resp_pa    = resp_q.pa;
    assign resp_wimg  = resp_q.wimg;
    assign resp_pp    = resp_q.pp;
    assign resp_fault = resp_q.fault;
    assign resp_idx   = resp_q.idx;
`ifdef MMU_BAT_MULTIHIT_EN
    assign resp_multihit = resp_q.multihit;
`endif
endmodule
